// File: rtl/period_check_pkg.sv
// Shared types and defaults for the period check monitor.
// Imported by the controller and its helpers.
package period_check_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE,
    DONE
  } pc_state_t;

  localparam int unsigned TIMEOUT_DEF = 1000;

endpackage

// File: rtl/rise_detect.sv
// One-flop rising-edge detector for a signal already in the clk domain.
// rise is high in the first cycle d is seen high.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic d_q;

  // history of d, one cycle behind
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/period_check_ctrl.sv
// Measures N consecutive evt_in periods against a [min,max] window.
// Flags pass/fail and aborts when edges stop for TIMEOUT cycles.
module period_check_ctrl
  import period_check_pkg::*;
#(
  parameter int PER_W   = 16,
  parameter int N_W     = 8,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N_W-1:0]   num_periods,
  input  logic [PER_W-1:0] exp_min,
  input  logic [PER_W-1:0] exp_max,
  input  logic             evt_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [N_W-1:0]   fail_cnt,
  output logic [PER_W-1:0] last_period
);

  localparam logic [PER_W-1:0] TO  = PER_W'(TIMEOUT);
  localparam logic [PER_W-1:0] TO1 = PER_W'(TIMEOUT - 1);
  localparam logic [PER_W-1:0] ONE = PER_W'(1);

  pc_state_t        state;
  pc_state_t        state_nxt;
  logic             rise;
  logic [PER_W-1:0] cnt;
  logic [PER_W-1:0] min_q;
  logic [PER_W-1:0] max_q;
  logic [N_W-1:0]   rem_q;

  logic acc;
  logic meas_rise;
  logic bad;
  logic to_ev;
  logic fail_inc;
  logic end_run;

  rise_detect u_rise (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (evt_in),
    .rise (rise)
  );

  assign acc       = (state == IDLE) && start;
  assign meas_rise = (state == MEASURE) && rise;
  assign bad       = (cnt < min_q) || (cnt > max_q);
  assign fail_inc  = meas_rise && bad;
  assign to_ev     = ((state == ARM) && !rise && (cnt == TO1))
                   | ((state == MEASURE) && !rise && (cnt == TO));
  assign end_run   = ((state == ARM) || (state == MEASURE))
                   && (state_nxt == DONE);

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start)
          state_nxt = (num_periods == '0) ? DONE : ARM;
      end
      ARM: begin
        if (rise)       state_nxt = MEASURE;
        else if (to_ev) state_nxt = DONE;
      end
      MEASURE: begin
        if (rise && (rem_q == N_W'(1))) state_nxt = DONE;
        else if (to_ev)                 state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // config latch, period/wait counter and remaining-period counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      rem_q <= '0;
      min_q <= '0;
      max_q <= '0;
    end else if (acc) begin
      cnt   <= '0;
      rem_q <= num_periods;
      min_q <= exp_min;
      max_q <= exp_max;
    end else if (state == ARM) begin
      if (rise)           cnt <= ONE;
      else if (cnt != '1) cnt <= cnt + ONE;
    end else if (state == MEASURE) begin
      if (rise) begin
        cnt <= ONE;
        if (rem_q != '0) rem_q <= rem_q - N_W'(1);
      end else if (cnt != '1) begin
        cnt <= cnt + ONE;
      end
    end
  end

  // result flags; pass is settled as the run ends so it is valid with done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_cnt    <= '0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      last_period <= '0;
    end else if (acc) begin
      fail_cnt <= '0;
      timeout  <= 1'b0;
      pass     <= (num_periods == '0);
    end else begin
      if (meas_rise)
        last_period <= cnt;
      if (fail_inc && (fail_cnt != '1))
        fail_cnt <= fail_cnt + N_W'(1);
      if (to_ev)
        timeout <= 1'b1;
      if (end_run)
        pass <= !to_ev && (fail_cnt == '0) && !fail_inc;
    end
  end

endmodule

// File: tb/tb_period_check_ctrl.sv
// Bench for period_check_ctrl: directed table, reset abort,
// and random runs against a rise-time based reference model.
module tb_period_check_ctrl;

  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  num_periods = '0;
  logic [15:0] exp_min = '0;
  logic [15:0] exp_max = '0;
  logic        evt_in = 1'b0;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [7:0]  fail_cnt;
  logic [15:0] last_period;

  int n_chk = 0;
  int n_fail = 0;

  bit ev [0:2047];

  int m_done;
  bit m_pass;
  bit m_to;
  int m_fail;
  int m_last = 0;

  typedef struct {
    int num; int mn; int mx;
    int first; int period; int w; int np;
    int noise; int e_done;
    bit e_pass; bit e_to;
    int e_fail; int e_last;
  } vec_t;

  vec_t tbl [0:10];

  period_check_ctrl #(
    .PER_W(16), .N_W(8), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .num_periods(num_periods), .exp_min(exp_min),
    .exp_max(exp_max), .evt_in(evt_in), .busy(busy),
    .done(done), .pass(pass), .timeout(timeout),
    .fail_cnt(fail_cnt), .last_period(last_period)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic build(input int first, input int period,
                       input int w, input int np);
    int idx;
    for (int i = 0; i < 2048; i++) ev[i] = 1'b0;
    for (int k = 0; k < np; k++)
      for (int j = 0; j < w; j++) begin
        idx = first + k * period + j;
        if (idx < 2048) ev[idx] = 1'b1;
      end
  endtask

  // expected outcome from the list of rise times (cycle 0 = first ARM cycle)
  task automatic model(input int num, input int mn, input int mx);
    int r[$];
    int prev;
    int per;
    for (int c = 0; c < 2048; c++)
      if (ev[c] && (c == 0 || !ev[c-1])) r.push_back(c);
    m_to = 0;
    m_fail = 0;
    if (num == 0) begin
      m_done = 0;
    end else if (r.size() == 0 || r[0] > TO - 1) begin
      m_to = 1;
      m_done = TO;
    end else begin
      prev = r[0];
      for (int k = 1; k <= num; k++) begin
        if (k < r.size() && r[k] - prev <= TO) begin
          per = r[k] - prev;
          m_last = per;
          if ((per < mn || per > mx) && m_fail < 255) m_fail++;
          prev = r[k];
        end else begin
          m_to = 1;
          m_done = prev + TO + 1;
          break;
        end
      end
      if (!m_to) m_done = prev + 1;
    end
    m_pass = (m_fail == 0) && !m_to;
  endtask

  task automatic run(input vec_t v, input string nm);
    int c;
    int got;
    int busy_bad;
    int s_pass, s_to, s_fail, s_last;
    build(v.first, v.period, v.w, v.np);
    @(negedge clk);
    evt_in = 1'b0;
    start = 1'b1;
    num_periods = 8'(v.num);
    exp_min = 16'(v.mn);
    exp_max = 16'(v.mx);
    @(posedge clk);
    #1;
    start = 1'b0;
    num_periods = 8'($urandom);
    exp_min = 16'($urandom);
    exp_max = 16'($urandom);
    c = 0;
    got = -1;
    busy_bad = 0;
    s_pass = 0; s_to = 0; s_fail = 0; s_last = 0;
    while (c < 2300 && got < 0) begin
      evt_in = (c < 2048) ? ev[c] : 1'b0;
      if (c == v.noise || c == v.e_done) begin
        start = 1'b1;
        num_periods = 8'd9;
        exp_min = 16'd0;
        exp_max = 16'd0;
      end else begin
        start = 1'b0;
      end
      if (!busy) busy_bad++;
      if (done) begin
        got = c;
        s_pass = int'(pass);
        s_to = int'(timeout);
        s_fail = int'(fail_cnt);
        s_last = int'(last_period);
      end
      @(posedge clk);
      #1;
      c++;
    end
    start = 1'b0;
    evt_in = 1'b0;
    chk({nm, " done_cycle"}, got, v.e_done);
    chk({nm, " busy_in_run"}, busy_bad, 0);
    chk({nm, " pass"}, s_pass, int'(v.e_pass));
    chk({nm, " timeout"}, s_to, int'(v.e_to));
    chk({nm, " fail_cnt"}, s_fail, v.e_fail);
    chk({nm, " last_period"}, s_last, v.e_last);
    chk({nm, " idle_after"}, int'(busy), 0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " busy"}, int'(busy), 0);
    chk({nm, " done"}, int'(done), 0);
    chk({nm, " pass"}, int'(pass), 0);
    chk({nm, " timeout"}, int'(timeout), 0);
    chk({nm, " fail_cnt"}, int'(fail_cnt), 0);
    chk({nm, " last_period"}, int'(last_period), 0);
  endtask

  initial begin
    vec_t v;
    tbl[0]  = '{4, 10, 10, 3, 10, 5, 20, -1, 44, 1, 0, 0, 10};
    tbl[1]  = '{4, 8, 10, 3, 12, 1, 20, -1, 52, 0, 0, 4, 12};
    tbl[2]  = '{4, 8, 10, 0, 0, 0, 0, -1, 100, 0, 1, 0, 12};
    tbl[3]  = '{0, 0, 0, 0, 10, 1, 20, -1, 0, 1, 0, 0, 12};
    tbl[4]  = '{4, 10, 10, 3, 10, 1, 20, 20, 44, 1, 0, 0, 10};
    tbl[5]  = '{3, 11, 9, 0, 10, 1, 20, -1, 31, 0, 0, 3, 10};
    tbl[6]  = '{5, 10, 10, 2, 10, 1, 3, -1, 123, 0, 1, 0, 10};
    tbl[7]  = '{1, 0, 200, 0, 100, 1, 2, -1, 101, 1, 0, 0, 100};
    tbl[8]  = '{1, 0, 200, 0, 101, 1, 2, -1, 101, 0, 1, 0, 100};
    tbl[9]  = '{1, 5, 5, 99, 5, 1, 2, -1, 105, 1, 0, 0, 5};
    tbl[10] = '{1, 5, 5, 100, 5, 1, 2, -1, 100, 0, 1, 0, 5};

    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run(tbl[i], $sformatf("vec%0d", i));
      m_last = tbl[i].e_last;
    end

    // async reset in the middle of a measurement
    build(3, 10, 5, 20);
    @(negedge clk);
    start = 1'b1;
    num_periods = 8'd4;
    exp_min = 16'd10;
    exp_max = 16'd10;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      evt_in = ev[c];
      @(posedge clk);
      #1;
    end
    chk("midrun busy", int'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midrun_rst");
    @(negedge clk);
    evt_in = 1'b0;
    rst_n = 1'b1;
    m_last = 0;
    run(tbl[0], "after_rst");
    m_last = 10;

    for (int i = 0; i < 14; i++) begin
      v.num = $urandom_range(0, 6);
      v.mn = $urandom_range(3, 15);
      v.mx = $urandom_range(3, 15);
      v.first = $urandom_range(0, 110);
      v.period = $urandom_range(3, 16);
      v.w = $urandom_range(1, v.period - 1);
      v.np = $urandom_range(0, 8);
      v.noise = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 40) : -1;
      build(v.first, v.period, v.w, v.np);
      model(v.num, v.mn, v.mx);
      v.e_done = m_done;
      v.e_pass = m_pass;
      v.e_to = m_to;
      v.e_fail = m_fail;
      v.e_last = m_last;
      run(v, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
